// File: rtl/mc_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : mc_fifo_drain
// Description : Pops flits from one multicast sub-FIFO and replicates each flit
//               to the NPORT outputs named in its destination mask.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_fifo_drain #(
    parameter int DATASIZE = 30,
    parameter int NPORT    = 4
) (
    input  logic                fifo_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] fifo_rdata,
    input  logic                fifo_empty_n,
    output logic                fifo_rd_en,
    output logic [DATASIZE-1:0] out_data,
    output logic [NPORT-1:0]    out_valid,
    input  logic [NPORT-1:0]    out_ready,
    output logic                pkt_active,
    output logic                err_nodest,
    output logic                err_proto
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [1:0] c_TYPE_BODY   = 2'b00;
    localparam logic [1:0] c_TYPE_HEAD   = 2'b01;
    localparam logic [1:0] c_TYPE_TAIL   = 2'b10;
    localparam logic [1:0] c_TYPE_SINGLE = 2'b11;

    logic [0:0]          r_state;
    logic [NPORT-1:0]    r_pending;
    logic [NPORT-1:0]    r_pkt_mask;
    logic                r_pkt_active;
    logic [DATASIZE-1:0] r_data;
    logic                r_err_nodest;
    logic                r_err_proto;

    logic [1:0]          w_type;
    logic [NPORT-1:0]    w_field;
    logic [NPORT-1:0]    w_remain;
    logic                w_load;
    logic                w_is_head;
    logic                w_drop_nodest;
    logic                w_drop_proto;
    logic                w_reopen;
    logic [NPORT-1:0]    w_next_mask;

    always_comb begin
        w_type        = fifo_rdata[DATASIZE-1 -: 2];
        w_field       = fifo_rdata[DATASIZE-3 -: NPORT];
        w_remain      = r_pending & ~out_ready;
        w_load        = ~rst & fifo_empty_n &
                        ((r_state == S_IDLE) || ((r_state == S_SEND) && (w_remain == '0)));
        w_is_head     = (w_type == c_TYPE_HEAD) || (w_type == c_TYPE_SINGLE);
        w_drop_nodest = w_is_head && (w_field == '0);
        w_drop_proto  = !w_is_head && !r_pkt_active;
        // A fresh head arriving inside an open packet is taken, but flagged.
        w_reopen      = w_is_head && !w_drop_nodest && r_pkt_active;
        w_next_mask   = '0;
        if (!w_drop_nodest && !w_drop_proto) begin
            w_next_mask = w_is_head ? w_field : r_pkt_mask;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_pkt_mask   <= '0;
            r_pkt_active <= 1'b0;
            r_data       <= '0;
            r_err_nodest <= 1'b0;
            r_err_proto  <= 1'b0;
        end else begin
            r_err_nodest <= 1'b0;
            r_err_proto  <= 1'b0;
            if (w_load) begin
                r_data       <= fifo_rdata;
                r_pending    <= w_next_mask;
                r_state      <= (w_next_mask != '0) ? S_SEND : S_IDLE;
                r_err_nodest <= w_drop_nodest;
                r_err_proto  <= w_drop_proto | w_reopen;
                if (!w_drop_nodest && !w_drop_proto) begin
                    case (w_type)
                        c_TYPE_HEAD: begin
                            r_pkt_mask   <= w_field;
                            r_pkt_active <= 1'b1;
                        end
                        c_TYPE_SINGLE,
                        c_TYPE_TAIL:  r_pkt_active <= 1'b0;
                        c_TYPE_BODY:  r_pkt_active <= r_pkt_active;
                        default:      r_pkt_active <= r_pkt_active;
                    endcase
                end
            end else if (r_state == S_SEND) begin
                r_pending <= w_remain;
                if (w_remain == '0) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign fifo_rd_en = w_load;
    assign out_data   = r_data;
    assign out_valid  = r_pending;
    assign pkt_active = r_pkt_active;
    assign err_nodest = r_err_nodest;
    assign err_proto  = r_err_proto;

endmodule
`default_nettype wire

// File: tb/tb_mc_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_fifo_drain
// Description : Directed and randomized self-checking bench for mc_fifo_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_fifo_drain;

    localparam int DATASIZE = 30;
    localparam int NPORT    = 4;
    localparam int PLW      = DATASIZE - 2 - NPORT;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATASIZE-1:0] fifo_rdata;
    logic                fifo_empty_n;
    logic                fifo_rd_en;
    logic [DATASIZE-1:0] out_data;
    logic [NPORT-1:0]    out_valid;
    logic [NPORT-1:0]    out_ready;
    logic                pkt_active;
    logic                err_nodest;
    logic                err_proto;

    always #5 clk = ~clk;

    mc_fifo_drain #(.DATASIZE(DATASIZE), .NPORT(NPORT)) dut (
        .fifo_clk     (clk),
        .rst          (rst),
        .fifo_rdata   (fifo_rdata),
        .fifo_empty_n (fifo_empty_n),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pkt_active   (pkt_active),
        .err_nodest   (err_nodest),
        .err_proto    (err_proto)
    );

    logic [DATASIZE-1:0] fq[$];
    logic [DATASIZE-1:0] pq[NPORT][$];
    logic [DATASIZE-1:0] exp_q[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  n_fail = 0;
    int  n_err = 0;
    bit  sb_on = 1'b0;
    bit  gaps  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATASIZE-1:0] mk(input logic [1:0] t, input logic [NPORT-1:0] m,
                                               input logic [PLW-1:0] pl);
        return {t, m, pl};
    endfunction

    task automatic settle();
        fifo_rdata   = (fq.size() > 0) ? fq[0] : '0;
        fifo_empty_n = (fq.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
        #1;
    endtask

    // Scores this cycle's handshakes, then advances one clock and pops the FIFO model.
    task automatic tick();
        logic popped;
        if (sb_on) begin
            for (int p = 0; p < NPORT; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    check($sformatf("port%0d_has_expected", p), 64'(pq[p].size() > 0), 64'd1);
                    if (pq[p].size() > 0) check($sformatf("port%0d_data", p), 64'(out_data), 64'(pq[p].pop_front()));
                end
            end
        end
        popped = fifo_rd_en;
        @(posedge clk);
        #1;
        if (popped && fq.size() > 0) void'(fq.pop_front());
        if (err_nodest || err_proto) n_err++;
        settle();
    endtask

    initial begin
        logic [NPORT-1:0] m;
        logic [PLW-1:0]   pl;
        int budget;
        int nflit;

        rst = 1'b1; out_ready = '0;
        settle();
        check("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
        tick(); tick();
        rst = 1'b0;
        settle();
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_flags", 64'({pkt_active, err_nodest, err_proto}), 64'd0);

        // 1: single to ports 0 and 2, all ready
        fq.push_back(mk(2'b11, 4'b0101, 24'h00_0001)); out_ready = 4'b1111; settle();
        check("t1_rd_en", 64'(fifo_rd_en), 64'd1);
        tick();
        check("t1_valid", 64'(out_valid), 64'h5);
        check("t1_data", 64'(out_data), 64'(mk(2'b11, 4'b0101, 24'h00_0001)));
        check("t1_rd_en_after", 64'(fifo_rd_en), 64'd0);
        tick();
        check("t1_idle", 64'(out_valid), 64'd0);

        // 2: broadcast with split acceptance; next flit pops only after the last handshake
        fq.push_back(mk(2'b11, 4'b1111, 24'h00_0002));
        fq.push_back(mk(2'b11, 4'b0001, 24'h00_0003));
        out_ready = 4'b0011; settle();
        tick();
        check("t2_valid_a", 64'(out_valid), 64'hF);
        check("t2_no_pop", 64'(fifo_rd_en), 64'd0);
        tick();
        check("t2_valid_b", 64'(out_valid), 64'hC);
        check("t2_no_pop_b", 64'(fifo_rd_en), 64'd0);
        out_ready = 4'b1100; settle();
        check("t2_pop", 64'(fifo_rd_en), 64'd1);
        tick();
        check("t2_next_valid", 64'(out_valid), 64'h1);
        check("t2_next_data", 64'(out_data), 64'(mk(2'b11, 4'b0001, 24'h00_0003)));
        out_ready = 4'b1111; settle();
        tick();
        check("t2_idle", 64'(out_valid), 64'd0);

        // 3: head/body/tail back-to-back
        fq.push_back(mk(2'b01, 4'b0110, 24'h00_0010));
        fq.push_back(mk(2'b00, 4'b1001, 24'h00_0011));
        fq.push_back(mk(2'b10, 4'b0000, 24'h00_0012));
        settle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_valid%0d", i), 64'(out_valid), 64'h6);
            check($sformatf("t3_data%0d", i), 64'(out_data[PLW-1:0]), 64'(24'h10 + i));
            check($sformatf("t3_active%0d", i), 64'(pkt_active), (i < 2) ? 64'd1 : 64'd0);
        end
        tick();
        check("t3_idle", 64'(out_valid), 64'd0);

        // 4: drops
        fq.push_back(mk(2'b01, 4'b0000, 24'h00_0020));
        fq.push_back(mk(2'b00, 4'b1111, 24'h00_0021));
        settle();
        tick();
        check("t4_nodest", 64'({err_nodest, err_proto}), 64'b10);
        check("t4_valid_a", 64'(out_valid), 64'd0);
        check("t4_active", 64'(pkt_active), 64'd0);
        tick();
        check("t4_proto", 64'({err_nodest, err_proto}), 64'b01);
        check("t4_valid_b", 64'(out_valid), 64'd0);
        check("t4_fifo_drained", 64'(fq.size()), 64'd0);
        tick();
        check("t4_pulse_end", 64'({err_nodest, err_proto}), 64'b00);

        // 5: reset while a head is stalled
        fq.push_back(mk(2'b01, 4'b1000, 24'h00_0030)); out_ready = 4'b0000; settle();
        tick(); tick();
        check("t5_held", 64'({pkt_active, out_valid}), 64'h18);
        rst = 1'b1; settle();
        tick();
        rst = 1'b0; settle();
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_active", 64'(pkt_active), 64'd0);
        check("t5_rd_en", 64'(fifo_rd_en), 64'd0);

        // 6: eight queued singles stream at one per cycle
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) fq.push_back(mk(2'b11, 4'b1111, PLW'(24'h100 + i)));
        settle();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_rd_en%0d", i), 64'(fifo_rd_en), 64'd1);
            tick();
            check($sformatf("t6_data%0d", i), 64'(out_data[PLW-1:0]), 64'(24'h100 + i));
            check($sformatf("t6_valid%0d", i), 64'(out_valid), 64'hF);
        end
        check("t6_rd_en_end", 64'(fifo_rd_en), 64'd0);
        tick();
        check("t6_idle", 64'(out_valid), 64'd0);

        // Random well-formed traffic: per-port delivery order against generation-time expectations
        nflit = 0;
        while (nflit < 250) begin
            m = NPORT'($urandom_range(1, (1 << NPORT) - 1));
            if ($urandom_range(0, 2) == 0) begin
                exp_q.push_back(mk(2'b11, m, PLW'($urandom())));
            end else begin
                exp_q.push_back(mk(2'b01, m, PLW'($urandom())));
                for (int b = $urandom_range(0, 3); b > 0; b--)
                    exp_q.push_back(mk(2'b00, NPORT'($urandom()), PLW'($urandom())));
                exp_q.push_back(mk(2'b10, NPORT'($urandom()), PLW'($urandom())));
            end
            // Flits after the head carry the head's destinations, whatever their own field says.
            while (exp_q.size() > 0) begin
                logic [DATASIZE-1:0] f;
                f = exp_q.pop_front();
                if (f[DATASIZE-1 -: 2] inside {2'b01, 2'b11}) m = f[DATASIZE-3 -: NPORT];
                fq.push_back(f);
                for (int p = 0; p < NPORT; p++) if (m[p]) pq[p].push_back(f);
                nflit++;
            end
        end
        sb_on = 1'b1; gaps = 1'b1; n_err = 0;
        budget = 20000;
        while (budget > 0 && (fq.size() > 0 || pq[0].size() > 0 || pq[1].size() > 0 ||
                              pq[2].size() > 0 || pq[3].size() > 0)) begin
            out_ready = NPORT'($urandom());
            settle();
            tick();
            budget--;
        end
        check("rnd_within_budget", 64'(budget > 0), 64'd1);
        check("rnd_fifo_empty", 64'(fq.size()), 64'd0);
        for (int p = 0; p < NPORT; p++)
            check($sformatf("rnd_port%0d_done", p), 64'(pq[p].size()), 64'd0);
        check("rnd_no_errors", 64'(n_err), 64'd0);
        out_ready = '0; settle();
        tick();
        check("rnd_idle", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
